tm1638_source_select: RTL

- Parametrised N-channel source selector between the TM1638 display sources and tm1638_driver.
- Successor to the fixed 8-way combinational stimulus mux. Adds:
  - per-channel capture of the latest frame;
  - next/prev stepping with wrap for any channel count;
  - optional auto-advance timer;
  - an immediate refresh frame to the driver on every channel switch, so the display never waits for a slow source.

---
 rtl/tm1638_source_select.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/tm1638_source_select.sv
// Purpose : N-channel source selector for tm1638_driver; holds the latest frame per channel, steps next/prev/auto.
// Latency : 1 cycle for live pass-through, 2 cycles from a step pulse to the refresh frame.
// Backpress: none; sources push one-cycle valid pulses, the driver must accept every o_Valid pulse.
module tm1638_source_select #(
    parameter int NUM_CH      = 8,
    parameter int SEG_W       = 64,
    parameter int LED_W       = 8,
    parameter int AUTO_CYCLES = 27_000_000,
    parameter int DEFAULT_SEL = 0
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic [NUM_CH*SEG_W-1:0]    i_Segments,
    input  logic [NUM_CH*LED_W-1:0]    i_Leds,
    input  logic [NUM_CH-1:0]          i_Valid,
    input  logic                       i_Next,
    input  logic                       i_Prev,
    input  logic                       i_Auto_En,
    output logic [SEG_W-1:0]           o_Segments,
    output logic [LED_W-1:0]           o_Leds,
    output logic                       o_Valid,
    output logic [$clog2(NUM_CH)-1:0]  o_Sel,
    output logic                       o_Switch
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(AUTO_CYCLES);

    // S_PASS forwards the selected channel live; S_REFRESH is the single
    // cycle after a channel switch where the held frame is replayed.
    typedef enum logic [0:0] {
        S_PASS    = 1'b0,
        S_REFRESH = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Unpacked views of the packed source buses.
    logic [SEG_W-1:0] in_seg [NUM_CH];
    logic [LED_W-1:0] in_led [NUM_CH];

    // Latest frame seen on every channel, selected or not.
    logic [SEG_W-1:0] hseg [NUM_CH];
    logic [LED_W-1:0] hled [NUM_CH];
    logic [NUM_CH-1:0] have;

    // Auto-advance interval counter.
    logic [CNT_W-1:0] auto_cnt;
    logic [CNT_W-1:0] auto_cnt_nxt;

    // Step decode.
    logic man_up;
    logic man_dn;
    logic auto_hit;
    logic step_up;
    logic step_dn;
    logic step;
    logic [SEL_W-1:0] sel_nxt;

    // Registered output next-values.
    logic [SEG_W-1:0] seg_nxt;
    logic [LED_W-1:0] led_nxt;
    logic             valid_nxt;
    logic             switch_nxt;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slice
            assign in_seg[k] = i_Segments[k*SEG_W +: SEG_W];
            assign in_led[k] = i_Leds[k*LED_W +: LED_W];
        end
    endgenerate

    // Resolve manual and automatic steps into a single +1/-1/0 decision.
    // Simultaneous next and prev cancel, and a cancelled pair still lets
    // the auto timer fire since the net manual step is zero.
    always_comb begin
        man_up   = i_Next & ~i_Prev;
        man_dn   = i_Prev & ~i_Next;
        auto_hit = i_Auto_En & ~man_up & ~man_dn &
                   (auto_cnt == CNT_W'(AUTO_CYCLES - 1));
        step_up  = man_up | auto_hit;
        step_dn  = man_dn;
        step     = step_up | step_dn;
    end

    // Wrapping channel arithmetic; works for any channel count, not only powers of two.
    always_comb begin
        sel_nxt = o_Sel;
        if (step_up) begin
            sel_nxt = (o_Sel == SEL_W'(NUM_CH - 1)) ? '0 : o_Sel + SEL_W'(1);
        end else if (step_dn) begin
            sel_nxt = (o_Sel == '0) ? SEL_W'(NUM_CH - 1) : o_Sel - SEL_W'(1);
        end
    end

    // Auto counter restarts on every step (so a manual press restarts the
    // interval) and idles at zero while auto mode is off.
    always_comb begin
        if (step || !i_Auto_En) begin
            auto_cnt_nxt = '0;
        end else begin
            auto_cnt_nxt = auto_cnt + CNT_W'(1);
        end
    end

    // Next-state and output decision. A step always wins: the old
    // channel's same-cycle frame is only captured, never forwarded, and a
    // step during a refresh simply restarts the refresh for the newer channel.
    always_comb begin
        state_nxt  = state;
        seg_nxt    = o_Segments;
        led_nxt    = o_Leds;
        valid_nxt  = 1'b0;
        switch_nxt = 1'b0;

        if (step) begin
            state_nxt  = S_REFRESH;
            switch_nxt = 1'b1;
        end else begin
            case (state)
                S_PASS: begin
                    if (i_Valid[o_Sel]) begin
                        seg_nxt   = in_seg[o_Sel];
                        led_nxt   = in_led[o_Sel];
                        valid_nxt = 1'b1;
                    end
                end
                S_REFRESH: begin
                    state_nxt = S_PASS;
                    // A live frame arriving now is newer than the held one.
                    if (i_Valid[o_Sel]) begin
                        seg_nxt   = in_seg[o_Sel];
                        led_nxt   = in_led[o_Sel];
                        valid_nxt = 1'b1;
                    end else if (have[o_Sel]) begin
                        seg_nxt   = hseg[o_Sel];
                        led_nxt   = hled[o_Sel];
                        valid_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_PASS;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= S_PASS;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture every channel's latest frame regardless of the selection.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            have <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                hseg[k] <= '0;
                hled[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (i_Valid[k]) begin
                    hseg[k] <= in_seg[k];
                    hled[k] <= in_led[k];
                    have[k] <= 1'b1;
                end
            end
        end
    end

    // Selection, auto counter and registered driver-facing outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Sel      <= SEL_W'(DEFAULT_SEL);
            auto_cnt   <= '0;
            o_Segments <= '0;
            o_Leds     <= '0;
            o_Valid    <= 1'b0;
            o_Switch   <= 1'b0;
        end else begin
            o_Sel      <= sel_nxt;
            auto_cnt   <= auto_cnt_nxt;
            o_Segments <= seg_nxt;
            o_Leds     <= led_nxt;
            o_Valid    <= valid_nxt;
            o_Switch   <= switch_nxt;
        end
    end

endmodule
